// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder/subtractor. Each RUN cycle ripples one
// CHUNK-bit slice through a row of full adders, and the carry is registered
// between slices. One operation takes N = WIDTH/CHUNK RUN cycles.
//
// Optional feature macro: ADDER_OVF_EN (adds the signed-overflow output ovf).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake (in_ready decoded from state)
//   a, b, cin, sub    operands, carry/borrow-in, 0=add 1=subtract
//   out_valid/out_ready result handshake (out_valid decoded from state)
//   sum, carry        result and carry-out (for sub: 1 = no borrow)
//   ovf               signed overflow (ADDER_OVF_EN only)

module seq_chunk_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [KW-1:0]    k;
    // Operands shift right one slice per RUN cycle so the active slice is
    // always in the low CHUNK bits. b_r holds b already inverted for subtract.
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c_r;

    logic [CHUNK:0]   ch;
    logic [CHUNK-1:0] sl;
    logic [WIDTH+CHUNK-1:0] sum_cat;
    logic [WIDTH+CHUNK-1:0] sum_sh;

    assign ch[0] = c_r;

    seq_chunk_fa u_fa [CHUNK-1:0] (
        .x  (a_r[CHUNK-1:0]),
        .y  (b_r[CHUNK-1:0]),
        .ci (ch[CHUNK-1:0]),
        .s  (sl),
        .co (ch[CHUNK:1])
    );

    // New slice enters at the top of sum; after N slices slice 0 sits at bit 0.
    assign sum_cat = {sl, sum};
    assign sum_sh  = sum_cat >> CHUNK;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
`ifdef ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        c_r   <= sub ? ~cin : cin;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_r <= a_r >> CHUNK;
                    b_r <= b_r >> CHUNK;
                    c_r <= ch[CHUNK];
                    sum <= sum_sh[WIDTH-1:0];
                    k   <= k + KW'(1);
                    if (k == K_LAST) begin
                        carry <= ch[CHUNK];
`ifdef ADDER_OVF_EN
                        // carry into MSB xor carry out of MSB
                        ovf   <= ch[CHUNK] ^ ch[CHUNK-1];
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three instances (CHUNK = 1, 4, 16 at WIDTH=16)
// share stimulus. A timeline model tracks each instance's pending operation
// and its expected result from plain integer arithmetic.
module tb_seq_chunk_adder;
    localparam int W = 16;
    localparam int NS [3] = '{16, 4, 1};

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [2:0] irdy, ovld, dcar;
    logic [W-1:0] dsum [3];
`ifdef ADDER_OVF_EN
    logic [2:0] dovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ovld[0]),
        .out_ready(out_ready), .sum(dsum[0]), .carry(dcar[0])
`ifdef ADDER_OVF_EN
        , .ovf(dovf[0])
`endif
    );
    seq_chunk_adder #(.WIDTH(W), .CHUNK(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ovld[1]),
        .out_ready(out_ready), .sum(dsum[1]), .carry(dcar[1])
`ifdef ADDER_OVF_EN
        , .ovf(dovf[1])
`endif
    );
    seq_chunk_adder #(.WIDTH(W), .CHUNK(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ovld[2]),
        .out_ready(out_ready), .sum(dsum[2]), .carry(dcar[2])
`ifdef ADDER_OVF_EN
        , .ovf(dovf[2])
`endif
    );

    // Reference arithmetic on wide integers.
    function automatic res_t ref_calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic ci, input logic sb);
        res_t r;
        longint u, sv;
        if (!sb) begin
            u   = longint'(x) + longint'(y) + longint'(ci);
            sv  = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
            r.c = (u >= (longint'(1) << W));
        end else begin
            u   = longint'(x) - longint'(y) - longint'(ci);
            sv  = longint'($signed(x)) - longint'($signed(y)) - longint'(ci);
            r.c = (u >= 0);
        end
        r.s = u[W-1:0];
        r.o = (sv >= (longint'(1) << (W-1))) || (sv < -(longint'(1) << (W-1)));
        return r;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, i, got, exp);
        end
    endtask

    // Model: pend = operation accepted and not yet consumed; cnt = edges since accept.
    logic [2:0] pend;
    int   cnt [3];
    res_t expr [3];
    int   done_ops [3] = '{0, 0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i]) begin
                    if (in_valid) begin
                        pend[i] <= 1'b1;
                        cnt[i]  <= 0;
                        expr[i] <= ref_calc(a, b, cin, sub);
                    end
                end else if (cnt[i] < NS[i]) begin
                    cnt[i] <= cnt[i] + 1;
                end else if (out_ready) begin
                    pend[i]     <= 1'b0;
                    done_ops[i] <= done_ops[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                logic ev;
                ev = pend[i] && (cnt[i] == NS[i]);
                chk("in_ready", i, 32'(irdy[i]), 32'(!pend[i]));
                chk("out_valid", i, 32'(ovld[i]), 32'(ev));
                if (ev) begin
                    chk("sum", i, 32'(dsum[i]), 32'(expr[i].s));
                    chk("carry", i, 32'(dcar[i]), 32'(expr[i].c));
`ifdef ADDER_OVF_EN
                    chk("ovf", i, 32'(dovf[i]), 32'(expr[i].o));
`endif
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        int waited = 0;
        while (irdy !== 3'b111 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        chk({nm, "_idle"}, 0, 32'(irdy), 32'h7);
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                          input logic tc, input logic ts,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        res_t m;
        int lat [3];
        m = ref_calc(ta, tb2, tc, ts);
        chk({nm, "_model_sum"}, 0, 32'(m.s), 32'(es));
        chk({nm, "_model_carry"}, 0, 32'(m.c), 32'(ec));
        chk({nm, "_model_ovf"}, 0, 32'(m.o), 32'(eo));
        wait_idle(nm);
        a = ta; b = tb2; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = '{0, 0, 0};
        for (int c = 1; c <= 40 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0); c++) begin
            // junk on inputs while busy must not disturb the result
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) if (ovld[i] && lat[i] == 0) lat[i] = c;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) chk({nm, "_latency"}, i, 32'(lat[i]), 32'(NS[i]));
        repeat (10) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                chk({nm, "_sum"}, i, 32'(dsum[i]), 32'(es));
                chk({nm, "_carry"}, i, 32'(dcar[i]), 32'(ec));
                chk({nm, "_busy"}, i, 32'(irdy[i]), 32'd0);
`ifdef ADDER_OVF_EN
                chk({nm, "_ovf"}, i, 32'(dovf[i]), 32'(eo));
`endif
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk({nm, "_release_rdy"}, i, 32'(irdy[i]), 32'd1);
            chk({nm, "_release_vld"}, i, 32'(ovld[i]), 32'd0);
        end
    endtask

    initial begin
        int target, s1, s2, cyc;
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", i, 32'(irdy[i]), 32'd1);
            chk("rst_out_valid", i, 32'(ovld[i]), 32'd0);
            chk("rst_sum", i, 32'(dsum[i]), 32'd0);
            chk("rst_carry", i, 32'(dcar[i]), 32'd0);
        end
        #1 rst_n = 1'b1;

        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_cin", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // reset two cycles into RUN
        wait_idle("mid_rst");
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_in_ready", i, 32'(irdy[i]), 32'd1);
            chk("mid_rst_out_valid", i, 32'(ovld[i]), 32'd0);
            chk("mid_rst_sum", i, 32'(dsum[i]), 32'd0);
            chk("mid_rst_carry", i, 32'(dcar[i]), 32'd0);
`ifdef ADDER_OVF_EN
            chk("mid_rst_ovf", i, 32'(dovf[i]), 32'd0);
`endif
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        run_op("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        // random traffic, checked every cycle by the compare process
        target = done_ops[0] + 1000;
        s1 = done_ops[1];
        s2 = done_ops[2];
        cyc = 0;
        while (done_ops[0] < target && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            in_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0: a = 16'h0000;
                1: a = 16'hFFFF;
                2: a = 16'h7FFF;
                3: a = 16'h8000;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: b = 16'h0000;
                1: b = 16'hFFFF;
                2: b = 16'h0001;
                3: b = 16'h8000;
                default: b = 16'($urandom);
            endcase
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("random_ops_c1", 0, 32'(done_ops[0] >= target), 32'd1);
        chk("random_ops_c4", 1, 32'(done_ops[1] - s1 >= 1000), 32'd1);
        chk("random_ops_c16", 2, 32'(done_ops[2] - s2 >= 1000), 32'd1);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Parametrised multi-cycle adder/subtractor for the arithmetic library. It is the clocked successor to the 4-bit ripple adder. Each cycle it ripples one CHUNK-bit slice through a chain of full adders and registers the carry between slices. An operation accepted on a valid/ready handshake completes in WIDTH/CHUNK cycles. This trades latency for a short carry path, so wide operands (16–64 bit) can sit in datapaths without a long ripple chain.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH
- N (localparam) = WIDTH/CHUNK, cycles per operation
- clk input 1, single clock, all state updates on rising edge
- rst_n input 1, asynchronous active-low reset
- in_valid input 1, operand request
- in_ready output 1, block can accept an operation
- a input WIDTH, operand A
- b input WIDTH, operand B
- cin input 1, carry-in (borrow-in when sub=1)
- sub input 1, 0 = add, 1 = subtract
- out_valid output 1, result available
- out_ready input 1, consumer accepts result
- sum output WIDTH, result
- carry output 1, carry-out (for sub: 1 = no borrow)
- ovf output 1, signed overflow; present only with ADDER_OVF_EN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready=1, out_valid=0.
  - On in_valid=1, capture a, b and sub; clear slice index k to 0.
  - Initial carry c0 = sub ? ~cin : cin. Go to RUN.
- RUN
  - in_ready=0, out_valid=0. in_valid is ignored.
  - Each cycle computes slice k: {c, sum[k*CHUNK +: CHUNK]} = a_k + (b_k ^ {CHUNK{sub}}) + c.
  - c is registered between slices; k increments.
  - After slice N-1, latch carry = final c and go to DONE.
- DONE
  - out_valid=1, in_ready=0. sum, carry and ovf are held stable.
  - On out_ready=1, go to IDLE.
- Arithmetic
  - sub=0: sum = (a + b + cin) mod 2^WIDTH.
  - sub=1: sum = (a − b − cin) mod 2^WIDTH, computed as a + ~b + ~cin.
  - carry is bit WIDTH of the unsigned result before inversion.
- sum bits may change during RUN. They are defined only while out_valid=1.
- Captured operands are internal registers. Changes on a/b/cin/sub after acceptance have no effect.
- CHUNK=WIDTH is legal. N=1, so RUN lasts exactly one cycle.
- Elaboration must fail if WIDTH % CHUNK ≠ 0.

## Timing
- Reset: while rst_n=0, asynchronously force:
  - state=IDLE, k=0, sum=0, carry=0, ovf=0, out_valid=0.
  - in_ready=1 (it is decoded from state).
- in_ready and out_valid are decoded directly from registered state, with no combinational path from inputs.
- Latency: accept edge T → RUN during cycles T+1..T+N → out_valid=1 from edge T+N.
- Throughput: one operation per N+2 cycles minimum (accept, N RUN cycles, one DONE cycle with out_ready=1).
- Backpressure: DONE persists indefinitely while out_ready=0, and outputs are held.
- out_ready while not in DONE is ignored.
- in_valid must stay high until the in_ready handshake. in_valid dropping in IDLE without acceptance has no effect.
- Reset asserted mid-RUN or mid-DONE aborts the operation; the result is discarded. The first post-reset edge with in_valid=1 starts a fresh operation.

## Configuration
- Macro: ADDER_OVF_EN.
- Defined:
  - ovf port exists, computed as (carry into MSB) XOR (carry out of MSB) of the final slice.
  - Latched with carry and held in DONE. Reset value 0.
- Undefined:
  - ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0001, cin=0, sub=0 → out_valid exactly 4 cycles after accept edge; sum=0x0000, carry=1, ovf=0.
- sub=1, a=0x0005, b=0x0007, cin=0 → sum=0xFFFE, carry=0. Repeat with a=0x0007, b=0x0005, cin=1 → sum=0x0001, carry=1.
- ADDER_OVF_EN: a=0x7FFF, b=0x0001, add → sum=0x8000, ovf=1, carry=0. a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1.
- Handshake:
  - Hold out_ready=0 for 10 cycles in DONE → sum/carry stable, in_ready=0.
  - Toggle in_valid and a/b during RUN → result unchanged.
  - out_ready=1 → IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst_n=0 two cycles into RUN → all outputs 0, in_ready=1 immediately. The next op a=0x1234, b=0x1111 → sum=0x2345.
- Parameter sweep: CHUNK∈{1,4,16} with WIDTH=16, 1000 random operations against a reference model → results match, latency = 16/4/1 cycles.
